// File: rtl/test_status_mmio.sv
// test_status_mmio: memory-mapped test verdict / step / cycle-count responder.
// Test programs write their verdict to TOHOST and progress to STEP; the block
// latches sticky done/pass/fail/timeout flags, freezes the cycle count on the
// verdict and requests a core halt once the test is over.
module test_status_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter logic [31:0] TIMEOUT   = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic        halt_o,
    output logic [30:0] fail_code_o,
    output logic [31:0] step_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_e;

    localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

    state_e      state_q, state_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] step_q, step_d;
    logic [31:0] data_q, data_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic        done_q, pass_q, fail_q, timeout_q;
    logic        done_d, pass_d, fail_d, timeout_d;

    logic        hit_s;
    logic [1:0]  off_s;
    logic        verdict_s;
    logic        step_wr_s;
    logic        expire_s;
    logic [31:0] rdata_s;

    assign hit_s     = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off_s     = addr_i[3:2];
    assign verdict_s = we_i & hit_s & (off_s == 2'd0) & data_i[0];
    assign step_wr_s = we_i & hit_s & (off_s == 2'd1);
    assign expire_s  = (TIMEOUT != 32'd0) && (cycle_q == TMO_LAST);

    // Next-state logic: first verdict wins, a verdict beats a same-cycle watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (verdict_s) begin
                    if (data_i == 32'h0000_0001) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (expire_s) begin
                    state_d = ST_TMO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PASS: state_d = ST_PASS;
            ST_FAIL: state_d = ST_FAIL;
            ST_TMO:  state_d = ST_TMO;
            default: state_d = ST_RUN;
        endcase
    end

    // Flag, counter, step and fail-code next values derived from the next state.
    always_comb begin
        done_d      = (state_d != ST_RUN);
        pass_d      = (state_d == ST_PASS);
        // A watchdog expiry is a failed test as well, so it also raises fail.
        fail_d      = (state_d == ST_FAIL) || (state_d == ST_TMO);
        timeout_d   = (state_d == ST_TMO);
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        step_d      = step_q;
        if ((state_q == ST_RUN) && (state_d == ST_FAIL)) begin
            fail_code_d = data_i[31:1];
        end else begin
            fail_code_d = fail_code_q;
        end
        if ((state_q == ST_RUN) && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end else begin
            cycle_d = cycle_q;
        end
        if (step_wr_s) begin
            step_d = data_i;
        end else begin
            step_d = step_q;
        end
    end

    // Read mux on pre-write register values; misses and TOHOST read as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (hit_s) begin
            case (off_s)
                2'd0:    rdata_s = 32'h0000_0000;
                2'd1:    rdata_s = step_q;
                2'd2:    rdata_s = cycle_q;
                2'd3:    rdata_s = {28'h000_0000, timeout_q, fail_q, pass_q, done_q};
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
        if (re_i) begin
            data_d = rdata_s;
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers with synchronous reset back to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cycle_q     <= 32'h0000_0000;
            step_q      <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            fail_code_q <= 31'h0000_0000;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            step_q      <= step_d;
            data_q      <= data_d;
            fail_code_q <= fail_code_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign data_o      = data_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign halt_o      = done_q;
    assign fail_code_o = fail_code_q;
    assign step_o      = step_q;

endmodule

// File: tb/tb_test_status_mmio.sv
// Directed bench for test_status_mmio: one instance with the default watchdog,
// one with TIMEOUT=20 for the expiry cases.
module tb_test_status_mmio;

    localparam logic [31:0] TOHOST = 32'h0000_F000;
    localparam logic [31:0] STEP   = 32'h0000_F004;
    localparam logic [31:0] CYCLE  = 32'h0000_F008;
    localparam logic [31:0] STATUS = 32'h0000_F00C;
    localparam logic [31:0] MISS   = 32'h0000_F020;

    logic clk;
    int   checks;
    int   errors;

    // instance A (default TIMEOUT)
    logic        rst_a, we_a, re_a;
    logic [31:0] addr_a, wdat_a, data_a;
    logic        done_a, pass_a, fail_a, tmo_a, halt_a;
    logic [30:0] code_a;
    logic [31:0] step_a;

    // instance B (TIMEOUT = 20)
    logic        rst_b, we_b, re_b;
    logic [31:0] addr_b, wdat_b, data_b;
    logic        done_b, pass_b, fail_b, tmo_b, halt_b;
    logic [30:0] code_b;
    logic [31:0] step_b;

    test_status_mmio dut_a (
        .clk(clk), .rst(rst_a), .we_i(we_a), .re_i(re_a), .addr_i(addr_a),
        .data_i(wdat_a), .data_o(data_a), .done_o(done_a), .pass_o(pass_a),
        .fail_o(fail_a), .timeout_o(tmo_a), .halt_o(halt_a),
        .fail_code_o(code_a), .step_o(step_a)
    );

    test_status_mmio #(.TIMEOUT(32'd20)) dut_b (
        .clk(clk), .rst(rst_b), .we_i(we_b), .re_i(re_b), .addr_i(addr_b),
        .data_i(wdat_b), .data_o(data_b), .done_o(done_b), .pass_o(pass_b),
        .fail_o(fail_b), .timeout_o(tmo_b), .halt_o(halt_b),
        .fail_code_o(code_b), .step_o(step_b)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit u, input logic [31:0] a, input logic [31:0] d);
        if (u) begin we_b = 1'b1; addr_b = a; wdat_b = d; end
        else   begin we_a = 1'b1; addr_a = a; wdat_a = d; end
        tick();
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic rd(input bit u, input logic [31:0] a);
        if (u) begin re_b = 1'b1; addr_b = a; end
        else   begin re_a = 1'b1; addr_a = a; end
        tick();
        re_a = 1'b0;
        re_b = 1'b0;
    endtask

    task automatic reset(input bit u);
        if (u) rst_b = 1'b1; else rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_a = 1'b0; we_a = 1'b0; re_a = 1'b0; addr_a = 32'h0; wdat_a = 32'h0;
        rst_b = 1'b0; we_b = 1'b0; re_b = 1'b0; addr_b = 32'h0; wdat_b = 32'h0;
        #2;

        // reset state of both instances
        reset(1'b0);
        reset(1'b1);
        chk("rst_done", {31'h0, done_a}, 32'h0);
        chk("rst_flags", {28'h0, tmo_a, fail_a, pass_a, halt_a}, 32'h0);
        chk("rst_code", {1'b0, code_a}, 32'h0);
        chk("rst_step", step_a, 32'h0);
        chk("rst_data", data_a, 32'h0);

        // 1: pass verdict at cycle 50, count frozen at 51
        reset(1'b0);
        idle(50);
        chk("t1_before", {29'h0, done_a, pass_a, halt_a}, 32'h0);
        wr(1'b0, TOHOST, 32'h0000_0001);
        chk("t1_flags", {27'h0, done_a, pass_a, halt_a, fail_a, tmo_a}, 32'h1C);
        idle(3);
        rd(1'b0, CYCLE);
        chk("t1_cycle", data_a, 32'd51);

        // 2: fail verdict with code, later verdict ignored
        reset(1'b0);
        wr(1'b0, TOHOST, 32'h0000_0007);
        chk("t2_flags", {28'h0, done_a, pass_a, fail_a, tmo_a}, 32'hA);
        chk("t2_code", {1'b0, code_a}, 32'd3);
        wr(1'b0, TOHOST, 32'h0000_0001);
        chk("t2_sticky", {28'h0, done_a, pass_a, fail_a, tmo_a}, 32'hA);
        chk("t2_code_hold", {1'b0, code_a}, 32'd3);
        rd(1'b0, STATUS);
        chk("t2_status", data_a, 32'h5);

        // 5: STEP in terminal state, miss access, simultaneous read/write
        wr(1'b0, STEP, 32'd38);
        chk("t5_step_o", step_a, 32'd38);
        rd(1'b0, STEP);
        chk("t5_step_rd", data_a, 32'd38);
        wr(1'b0, MISS, 32'hFFFF_FFFF);
        chk("t5_miss_step", step_a, 32'd38);
        chk("t5_miss_flags", {28'h0, done_a, pass_a, fail_a, tmo_a}, 32'hA);
        rd(1'b0, MISS);
        chk("t5_miss_rd", data_a, 32'h0);
        we_a = 1'b1; re_a = 1'b1; addr_a = STEP; wdat_a = 32'd99;
        tick();
        we_a = 1'b0; re_a = 1'b0;
        chk("t5_rw_data", data_a, 32'd38);
        chk("t5_rw_step", step_a, 32'd99);
        rd(1'b0, TOHOST);
        chk("t5_tohost_rd", data_a, 32'h0);

        // 3: watchdog expiry, TIMEOUT=20
        reset(1'b1);
        idle(19);
        chk("t3_not_yet", {30'h0, done_b, tmo_b}, 32'h0);
        tick();
        chk("t3_expired", {28'h0, done_b, tmo_b, halt_b, pass_b}, 32'hE);
        rd(1'b1, STATUS);
        chk("t3_status", data_b, 32'hD);
        rd(1'b1, CYCLE);
        chk("t3_cycle", data_b, 32'd20);

        // 4: verdict on the expiry cycle wins
        reset(1'b1);
        idle(19);
        wr(1'b1, TOHOST, 32'h0000_0001);
        chk("t4_flags", {28'h0, done_b, pass_b, fail_b, tmo_b}, 32'hC);
        idle(2);
        chk("t4_no_tmo", {31'h0, tmo_b}, 32'h0);

        // 6: reset mid-test clears everything, count restarts
        reset(1'b0);
        wr(1'b0, STEP, 32'd5);
        rd(1'b0, STEP);
        wr(1'b0, TOHOST, 32'h0000_0001);
        chk("t6_pass", {30'h0, done_a, pass_a}, 32'h3);
        reset(1'b0);
        chk("t6_flags", {27'h0, done_a, pass_a, fail_a, tmo_a, halt_a}, 32'h0);
        chk("t6_step", step_a, 32'h0);
        chk("t6_data", data_a, 32'h0);
        idle(3);
        rd(1'b0, CYCLE);
        chk("t6_cycle", data_a, 32'd3);
        wr(1'b0, TOHOST, 32'h0000_0003);
        chk("t6_fail", {29'h0, done_a, pass_a, fail_a}, 32'h5);
        chk("t6_code", {1'b0, code_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
